// File: rtl/debug_unit_pkg.sv
// Purpose: shared constants for the host debug unit: latch widths, command
// codes, FSM state encoding and the bytes-per-field helper.
package debug_pkg;

  localparam int unsigned SIZE            = 32;
  localparam int unsigned NUM_REGISTERS   = 32;
  localparam int unsigned MAX_INSTRUCTION = 64;
  localparam int unsigned IF_ID_SIZE      = 32;
  localparam int unsigned ID_EX_SIZE      = 129;
  localparam int unsigned EX_MEM_SIZE     = 77;
  localparam int unsigned MEM_WB_SIZE     = 71;

  // Widest field the serializer can shift out (ID/EX rounded up to bytes).
  localparam int unsigned SNAP_W = 136;

  localparam logic [7:0] CMD_REGS  = 8'h01;
  localparam logic [7:0] CMD_IFID  = 8'h02;
  localparam logic [7:0] CMD_IDEX  = 8'h03;
  localparam logic [7:0] CMD_EXMEM = 8'h04;
  localparam logic [7:0] CMD_MEMWB = 8'h05;
  localparam logic [7:0] CMD_LOAD  = 8'h07;
  localparam logic [7:0] CMD_CONT  = 8'h08;
  localparam logic [7:0] CMD_STEPM = 8'h09;
  localparam logic [7:0] CMD_STEP  = 8'h0A;
  localparam logic [7:0] CMD_START = 8'h0D;
  localparam logic [7:0] CMD_PRST  = 8'h11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_CNT,
    ST_LOAD_BYTE,
    ST_LOAD_WR,
    ST_SEND,
    ST_SEND_WAIT
  } state_t;

  // ceil(width/8): bytes needed to send a field, top byte zero-padded.
  function automatic logic [7:0] byte_count(input int unsigned width);
    return 8'((width + 32'd7) / 32'd8);
  endfunction

  localparam logic [7:0] REG_BYTES    = byte_count(SIZE);
  localparam logic [7:0] IF_ID_BYTES  = byte_count(IF_ID_SIZE);
  localparam logic [7:0] ID_EX_BYTES  = byte_count(ID_EX_SIZE);
  localparam logic [7:0] EX_MEM_BYTES = byte_count(EX_MEM_SIZE);
  localparam logic [7:0] MEM_WB_BYTES = byte_count(MEM_WB_SIZE);

endpackage

// File: rtl/debug_unit_if.sv
// Purpose: UART-side byte stream of the debug unit.
//   i_rx_data/i_rx_valid : received byte and its one-cycle strobe
//   i_tx_done            : transmitter finished the current byte
//   o_tx_data/o_tx_start : byte to send and its one-cycle start strobe
// slave = debug unit side, master = UART / host model side.
interface debug_unit_if;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_tx_done;
  logic [7:0] o_tx_data;
  logic       o_tx_start;

  modport slave  (input  i_rx_data, i_rx_valid, i_tx_done,
                  output o_tx_data, o_tx_start);
  modport master (output i_rx_data, i_rx_valid, i_tx_done,
                  input  o_tx_data, o_tx_start);
endinterface

// File: rtl/debug_tx_serializer.sv
// Purpose: shifts a loaded word out LSB byte first over the tx handshake.
//   i_load/i_word/i_nbytes : capture a word and how many bytes to send
//   i_tx_done              : transmitter finished the current byte
//   o_tx_data/o_tx_start   : byte and one-cycle start strobe
//   o_done                 : one-cycle pulse after the last byte completes
module debug_tx_serializer
  import debug_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [SNAP_W-1:0] i_word,
  input  logic [7:0]        i_nbytes,
  input  logic              i_tx_done,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_start,
  output logic              o_done
);

  logic [SNAP_W-1:0] r_shift;
  logic [7:0]        r_left;
  logic [7:0]        r_tx_data;
  logic              r_busy;
  logic              r_start;
  logic              r_done;

  // r_shift holds the bytes not yet handed to the transmitter.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shift   <= '0;
      r_left    <= '0;
      r_tx_data <= '0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (i_load) begin
        r_shift   <= i_word >> 8;
        r_left    <= i_nbytes;
        r_tx_data <= i_word[7:0];
        r_start   <= 1'b1;
        r_busy    <= 1'b1;
      end else if (r_busy && i_tx_done) begin
        if (r_left == 8'd1) begin
          r_left <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_left    <= r_left - 8'd1;
          r_tx_data <= r_shift[7:0];
          r_shift   <= r_shift >> 8;
          r_start   <= 1'b1;
        end
      end
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_start;
  assign o_done     = r_done;

endmodule

// File: rtl/debug_unit.sv
// Purpose: on-chip end of the host debug protocol. Decodes host commands,
// loads programs into instruction memory, controls run/step/stall and dumps
// registers and pipeline latches back to the host.
//   i_clk, i_rst (async, active-low)
//   uart          : rx byte stream in, tx byte stream out
//   o_reg_addr / i_reg_data            : register-file read port
//   i_if_id, i_id_ex, i_ex_mem, i_mem_wb : live pipeline latches
//   o_imem_we / o_imem_addr / o_imem_data : instruction-memory write port
//   o_stall, o_pipe_rst, o_step_mode, o_overrun : pipeline control/status
module debug_unit
  import debug_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  debug_unit_if.slave            uart,
  output logic [4:0]             o_reg_addr,
  input  logic [SIZE-1:0]        i_reg_data,
  input  logic [IF_ID_SIZE-1:0]  i_if_id,
  input  logic [ID_EX_SIZE-1:0]  i_id_ex,
  input  logic [EX_MEM_SIZE-1:0] i_ex_mem,
  input  logic [MEM_WB_SIZE-1:0] i_mem_wb,
  output logic                   o_imem_we,
  output logic [5:0]             o_imem_addr,
  output logic [SIZE-1:0]        o_imem_data,
  output logic                   o_stall,
  output logic                   o_pipe_rst,
  output logic                   o_step_mode,
  output logic                   o_overrun
);

  localparam logic [4:0] LAST_REG = 5'(NUM_REGISTERS - 1);

  state_t            r_state;
  logic              r_pend_valid;
  logic [7:0]        r_pend_byte;
  logic              r_dump_regs;
  logic [4:0]        r_reg_idx;
  logic [SNAP_W-1:0] r_snap;
  logic [7:0]        r_snap_n;
  logic [7:0]        r_load_n;
  logic [7:0]        r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [SIZE-1:0]   r_word;
  logic              r_imem_we;
  logic [5:0]        r_imem_addr;
  logic [SIZE-1:0]   r_imem_data;
  logic              r_stall;
  logic              r_pipe_rst;
  logic              r_step_mode;
  logic              r_armed;
  logic              r_overrun;

  logic              w_byte_valid;
  logic [7:0]        w_byte;
  logic              w_take;
  logic              w_ser_load;
  logic              w_ser_done;
  logic [SNAP_W-1:0] w_ser_word;
  logic [7:0]        w_ser_n;

  // A held byte always goes before a fresh one so arrival order is kept.
  assign w_byte_valid = r_pend_valid | uart.i_rx_valid;
  assign w_byte       = r_pend_valid ? r_pend_byte : uart.i_rx_data;
  assign w_take       = w_byte_valid && (r_state == ST_IDLE ||
                                         r_state == ST_LOAD_CNT ||
                                         r_state == ST_LOAD_BYTE);

  // Registers are read live at load time; latches come from the snapshot.
  assign w_ser_load = (r_state == ST_SEND);
  assign w_ser_word = r_dump_regs ? SNAP_W'(i_reg_data) : r_snap;
  assign w_ser_n    = r_dump_regs ? REG_BYTES : r_snap_n;

  debug_tx_serializer u_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_ser_load),
    .i_word     (w_ser_word),
    .i_nbytes   (w_ser_n),
    .i_tx_done  (uart.i_tx_done),
    .o_tx_data  (uart.o_tx_data),
    .o_tx_start (uart.o_tx_start),
    .o_done     (w_ser_done)
  );

  // Command FSM, pending-byte slot and pipeline control.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_byte  <= '0;
      r_dump_regs  <= 1'b0;
      r_reg_idx    <= '0;
      r_snap       <= '0;
      r_snap_n     <= '0;
      r_load_n     <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_data  <= '0;
      r_stall      <= 1'b1;
      r_pipe_rst   <= 1'b0;
      r_step_mode  <= 1'b0;
      r_armed      <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_pipe_rst <= 1'b0;
      r_imem_we  <= 1'b0;
      // In step mode an unstall lasts exactly one cycle.
      if (r_step_mode) r_stall <= 1'b1;

      // Pending slot: refill when the held byte is consumed, otherwise
      // park bytes that arrive while the FSM cannot take them.
      if (w_take && r_pend_valid) begin
        r_pend_valid <= uart.i_rx_valid;
        r_pend_byte  <= uart.i_rx_data;
      end else if (!w_take && uart.i_rx_valid) begin
        if (!r_pend_valid) begin
          r_pend_valid <= 1'b1;
          r_pend_byte  <= uart.i_rx_data;
        end else begin
          r_overrun <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            case (w_byte)
              CMD_REGS: begin
                r_dump_regs <= 1'b1;
                r_reg_idx   <= '0;
                r_state     <= ST_SEND;
              end
              CMD_IFID: begin
                r_snap   <= SNAP_W'(i_if_id);
                r_snap_n <= IF_ID_BYTES;
                r_state  <= ST_SEND;
              end
              CMD_IDEX: begin
                r_snap   <= SNAP_W'(i_id_ex);
                r_snap_n <= ID_EX_BYTES;
                r_state  <= ST_SEND;
              end
              CMD_EXMEM: begin
                r_snap   <= SNAP_W'(i_ex_mem);
                r_snap_n <= EX_MEM_BYTES;
                r_state  <= ST_SEND;
              end
              CMD_MEMWB: begin
                r_snap   <= SNAP_W'(i_mem_wb);
                r_snap_n <= MEM_WB_BYTES;
                r_state  <= ST_SEND;
              end
              CMD_LOAD: begin
                r_stall    <= 1'b1;
                r_pipe_rst <= 1'b1;
                r_state    <= ST_LOAD_CNT;
              end
              CMD_CONT: r_step_mode <= 1'b0;
              CMD_STEPM: begin
                r_step_mode <= 1'b1;
                r_stall     <= 1'b1;
              end
              CMD_START: begin
                r_armed <= 1'b1;
                if (!r_step_mode) r_stall <= 1'b0;
              end
              CMD_STEP: begin
                if (r_step_mode && r_armed) r_stall <= 1'b0;
              end
              CMD_PRST: begin
                r_pipe_rst <= 1'b1;
                r_stall    <= 1'b1;
                r_armed    <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD_CNT: begin
          if (w_take) begin
            r_load_n   <= w_byte;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_state    <= (w_byte == 8'd0) ? ST_IDLE : ST_LOAD_BYTE;
          end
        end
        ST_LOAD_BYTE: begin
          // Little-endian: the first byte ends up in bits 7:0.
          if (w_take) begin
            r_word     <= {w_byte, r_word[SIZE-1:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) r_state <= ST_LOAD_WR;
          end
        end
        ST_LOAD_WR: begin
          // Words past the end of instruction memory are swallowed.
          if (r_word_idx < 8'(MAX_INSTRUCTION)) begin
            r_imem_we   <= 1'b1;
            r_imem_addr <= 6'(r_word_idx);
            r_imem_data <= r_word;
          end
          r_word_idx <= r_word_idx + 8'd1;
          r_state    <= (r_word_idx + 8'd1 == r_load_n) ? ST_IDLE : ST_LOAD_BYTE;
        end
        ST_SEND: r_state <= ST_SEND_WAIT;
        ST_SEND_WAIT: begin
          if (w_ser_done) begin
            if (r_dump_regs && r_reg_idx != LAST_REG) begin
              r_reg_idx <= r_reg_idx + 5'd1;
              r_state   <= ST_SEND;
            end else begin
              r_reg_idx   <= '0;
              r_dump_regs <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_reg_addr  = r_reg_idx;
  assign o_imem_we   = r_imem_we;
  assign o_imem_addr = r_imem_addr;
  assign o_imem_data = r_imem_data;
  assign o_stall     = r_stall;
  assign o_pipe_rst  = r_pipe_rst;
  assign o_step_mode = r_step_mode;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_debug_unit.sv
// Purpose: directed self-checking bench for debug_unit with a UART tx
// responder, register-file model and write/stall/reset monitors.
module tb_debug_unit;
  import debug_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic [4:0]             reg_addr;
  logic [SIZE-1:0]        reg_data;
  logic [IF_ID_SIZE-1:0]  if_id;
  logic [ID_EX_SIZE-1:0]  id_ex;
  logic [EX_MEM_SIZE-1:0] ex_mem;
  logic [MEM_WB_SIZE-1:0] mem_wb;
  logic                   imem_we;
  logic [5:0]             imem_addr;
  logic [SIZE-1:0]        imem_data;
  logic                   stall;
  logic                   pipe_rst;
  logic                   step_mode;
  logic                   overrun;

  debug_unit_if u ();

  debug_unit dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .uart        (u),
    .o_reg_addr  (reg_addr),
    .i_reg_data  (reg_data),
    .i_if_id     (if_id),
    .i_id_ex     (id_ex),
    .i_ex_mem    (ex_mem),
    .i_mem_wb    (mem_wb),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_data (imem_data),
    .o_stall     (stall),
    .o_pipe_rst  (pipe_rst),
    .o_step_mode (step_mode),
    .o_overrun   (overrun)
  );

  // Register file model: r[i] = i * 16'h0101.
  assign reg_data = {16'h0000, 3'b000, reg_addr, 3'b000, reg_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests;
  int          n_fail;
  logic [7:0]  tx_q[$];
  int          tx_timer;
  int          tx_overlap;
  int          prst_cnt;
  int          stall_low;
  int          stall_pulses;
  logic        prev_stall;
  logic [5:0]  we_addr_q[$];
  logic [31:0] we_data_q[$];

  // UART tx responder (3-cycle byte time) plus output monitors.
  initial begin
    u.i_tx_done  = 1'b0;
    tx_timer     = 0;
    tx_overlap   = 0;
    prst_cnt     = 0;
    stall_low    = 0;
    stall_pulses = 0;
    prev_stall   = 1'b1;
    forever begin
      @(negedge clk);
      u.i_tx_done = 1'b0;
      if (!rst_n) begin
        tx_timer = 0;
      end else begin
        if (u.o_tx_start) begin
          if (tx_timer != 0) tx_overlap++;
          tx_q.push_back(u.o_tx_data);
        end
        if (tx_timer != 0) begin
          tx_timer--;
          if (tx_timer == 0) u.i_tx_done = 1'b1;
        end
        if (u.o_tx_start) tx_timer = 3;
      end
      if (pipe_rst) prst_cnt++;
      if (imem_we) begin
        we_addr_q.push_back(imem_addr);
        we_data_q.push_back(imem_data);
      end
      if (!stall) stall_low++;
      if (!stall && prev_stall) stall_pulses++;
      prev_stall = stall;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u.i_rx_data  = b;
    u.i_rx_valid = 1'b1;
    @(negedge clk);
    u.i_rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input int target, input string name);
    int cyc = 0;
    while (tx_q.size() < target && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (30) @(negedge clk);
    n_tests++;
    if (tx_q.size() != target) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes, expected %0d", name, tx_q.size(), target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b expected 1", stall); end
    n_tests++;
    if ({u.o_tx_start, pipe_rst, step_mode, overrun, imem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {u.o_tx_start, pipe_rst, step_mode, overrun, imem_we});
    end
    n_tests++;
    if (reg_addr !== 5'd0 || imem_addr !== 6'd0 || imem_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h/%h/%h expected 0/0/0", reg_addr, imem_addr, imem_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_dump();
    int base;
    send_byte(CMD_REGS);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = tx_q.size();
    repeat (40) @(negedge clk);
    n_tests++;
    if (tx_q.size() != base) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d bytes after reset, expected 0", tx_q.size() - base);
    end
    n_tests++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL midreset_stall: got %b expected 1", stall); end
    if_id = 32'hDEADBEEF;
    send_byte(CMD_IFID);
    wait_bytes(base + 4, "midreset_ifid");
    if (tx_q.size() == base + 4) begin
      n_tests++;
      if ({tx_q[base+3], tx_q[base+2], tx_q[base+1], tx_q[base]} !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL midreset_ifid_data: got %h%h%h%h expected deadbeef",
                 tx_q[base+3], tx_q[base+2], tx_q[base+1], tx_q[base]);
      end
    end
  endtask

  task automatic test_load();
    int we0;
    int p0;
    logic [7:0] prog[8];
    prog = '{8'h01, 8'h01, 8'h01, 8'h3C, 8'h03, 8'h00, 8'h03, 8'h3C};
    we0 = we_addr_q.size();
    p0  = prst_cnt;
    send_byte(CMD_LOAD);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    repeat (5) @(negedge clk);
    n_tests++;
    if (we_addr_q.size() != we0 + 2) begin
      n_fail++;
      $display("FAIL load_we_count: got %0d expected 2", we_addr_q.size() - we0);
    end else begin
      n_tests++;
      if (we_addr_q[we0] !== 6'd0 || we_data_q[we0] !== 32'h3C010101) begin
        n_fail++;
        $display("FAIL load_word0: got %0d/%h expected 0/3c010101", we_addr_q[we0], we_data_q[we0]);
      end
      n_tests++;
      if (we_addr_q[we0+1] !== 6'd1 || we_data_q[we0+1] !== 32'h3C030003) begin
        n_fail++;
        $display("FAIL load_word1: got %0d/%h expected 1/3c030003", we_addr_q[we0+1], we_data_q[we0+1]);
      end
    end
    n_tests++;
    if (stall !== 1'b1 || prst_cnt != p0 + 1) begin
      n_fail++;
      $display("FAIL load_stall_prst: got stall=%b pulses=%0d expected stall=1 pulses=1", stall, prst_cnt - p0);
    end
    // N = 0 loads nothing and returns to command decoding.
    we0 = we_addr_q.size();
    send_byte(CMD_LOAD);
    send_byte(8'h00);
    send_byte(CMD_PRST);
    n_tests++;
    if (we_addr_q.size() != we0 || prst_cnt != p0 + 3) begin
      n_fail++;
      $display("FAIL load_zero: got writes=%0d pulses=%0d expected writes=0 pulses=3",
               we_addr_q.size() - we0, prst_cnt - p0);
    end
    // 65 words: the last one is beyond memory and must not be written.
    we0 = we_addr_q.size();
    send_byte(CMD_LOAD);
    send_byte(8'd65);
    for (int k = 0; k < 65; k++) begin
      send_byte(8'(k));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (we_addr_q.size() != we0 + 64) begin
      n_fail++;
      $display("FAIL load_max_count: got %0d expected 64", we_addr_q.size() - we0);
    end else begin
      n_tests++;
      if (we_addr_q[we0+63] !== 6'd63 || we_data_q[we0+63] !== 32'd63) begin
        n_fail++;
        $display("FAIL load_max_last: got %0d/%h expected 63/0000003f", we_addr_q[we0+63], we_data_q[we0+63]);
      end
    end
  endtask

  task automatic test_latch_dump();
    int base;
    int bad;
    logic [7:0] exp_b;
    base  = tx_q.size();
    id_ex = {1'b1, 120'd0, 8'hAB};
    @(negedge clk);
    u.i_rx_data  = CMD_IDEX;
    u.i_rx_valid = 1'b1;
    @(negedge clk);
    u.i_rx_valid = 1'b0;
    id_ex = '0;
    n_tests++;
    if (u.o_tx_start !== 1'b0) begin n_fail++; $display("FAIL idex_early_start: got 1 expected 0"); end
    @(negedge clk);
    n_tests++;
    if (u.o_tx_start !== 1'b1) begin n_fail++; $display("FAIL idex_latency: got 0 expected 1"); end
    wait_bytes(base + 17, "idex");
    if (tx_q.size() == base + 17) begin
      bad = 0;
      for (int i = 0; i < 17; i++) begin
        exp_b = (i == 0) ? 8'hAB : ((i == 16) ? 8'h01 : 8'h00);
        if (tx_q[base+i] !== exp_b) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL idex_bytes: got %0d wrong bytes expected 0", bad); end
    end
    n_tests++;
    if (tx_overlap != 0) begin n_fail++; $display("FAIL tx_handshake: got %0d overlaps expected 0", tx_overlap); end
    base   = tx_q.size();
    ex_mem = {5'h1F, 64'd0, 8'h5A};
    send_byte(CMD_EXMEM);
    wait_bytes(base + 10, "exmem");
    if (tx_q.size() == base + 10) begin
      n_tests++;
      if (tx_q[base] !== 8'h5A || tx_q[base+8] !== 8'h00 || tx_q[base+9] !== 8'h1F) begin
        n_fail++;
        $display("FAIL exmem_bytes: got %h..%h,%h expected 5a..00,1f", tx_q[base], tx_q[base+8], tx_q[base+9]);
      end
    end
  endtask

  task automatic test_regs();
    int base;
    int bad;
    logic [7:0] exp_b;
    base = tx_q.size();
    send_byte(CMD_REGS);
    wait_bytes(base + 128, "regs");
    if (tx_q.size() == base + 128) begin
      n_tests++;
      if ({tx_q[base+4], tx_q[base+5], tx_q[base+6], tx_q[base+7]} !== 32'h01010000) begin
        n_fail++;
        $display("FAIL regs_r1: got %h %h %h %h expected 01 01 00 00",
                 tx_q[base+4], tx_q[base+5], tx_q[base+6], tx_q[base+7]);
      end
      bad = 0;
      for (int j = 0; j < 128; j++) begin
        exp_b = ((j % 4) < 2) ? 8'(j / 4) : 8'h00;
        if (tx_q[base+j] !== exp_b) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL regs_all: got %0d wrong bytes expected 0", bad); end
    end
  endtask

  task automatic test_step();
    int l0;
    int s0;
    int p0;
    l0 = stall_low;
    send_byte(CMD_STEPM);
    send_byte(CMD_STEP);
    n_tests++;
    if (stall_low != l0 || step_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL step_unarmed: got low=%0d mode=%b expected low=0 mode=1", stall_low - l0, step_mode);
    end
    send_byte(CMD_START);
    n_tests++;
    if (stall_low != l0 || stall !== 1'b1) begin
      n_fail++;
      $display("FAIL step_start: got low=%0d stall=%b expected low=0 stall=1", stall_low - l0, stall);
    end
    s0 = stall_pulses;
    send_byte(CMD_STEP);
    send_byte(CMD_STEP);
    n_tests++;
    if (stall_pulses != s0 + 2 || stall_low != l0 + 2) begin
      n_fail++;
      $display("FAIL step_pulses: got pulses=%0d low=%0d expected pulses=2 low=2", stall_pulses - s0, stall_low - l0);
    end
    send_byte(CMD_CONT);
    send_byte(CMD_START);
    repeat (5) @(negedge clk);
    n_tests++;
    if (stall !== 1'b0 || step_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_run: got stall=%b mode=%b expected 0/0", stall, step_mode);
    end
    p0 = prst_cnt;
    send_byte(CMD_PRST);
    n_tests++;
    if (stall !== 1'b1 || prst_cnt != p0 + 1) begin
      n_fail++;
      $display("FAIL prst: got stall=%b pulses=%0d expected 1/1", stall, prst_cnt - p0);
    end
    l0 = stall_low;
    send_byte(CMD_STEPM);
    send_byte(CMD_STEP);
    n_tests++;
    if (stall_low != l0) begin
      n_fail++;
      $display("FAIL step_disarmed: got low=%0d expected 0", stall_low - l0);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got 1 expected 0"); end
    if_id = 32'h11223344;
    base  = tx_q.size();
    send_byte(CMD_REGS);
    repeat (10) @(negedge clk);
    send_byte(CMD_IFID);
    repeat (10) @(negedge clk);
    send_byte(CMD_IDEX);
    wait_bytes(base + 132, "b2b");
    if (tx_q.size() == base + 132) begin
      n_tests++;
      if ({tx_q[base+128], tx_q[base+129], tx_q[base+130], tx_q[base+131]} !== 32'h44332211) begin
        n_fail++;
        $display("FAIL b2b_pending: got %h %h %h %h expected 44 33 22 11",
                 tx_q[base+128], tx_q[base+129], tx_q[base+130], tx_q[base+131]);
      end
      n_tests++;
      if (tx_q[base+4] !== 8'h01 || tx_q[base+127] !== 8'h00) begin
        n_fail++;
        $display("FAIL b2b_dump: got %h/%h expected 01/00", tx_q[base+4], tx_q[base+127]);
      end
    end
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got 0 expected 1"); end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    u.i_rx_data  = 8'h00;
    u.i_rx_valid = 1'b0;
    if_id        = '0;
    id_ex        = '0;
    ex_mem       = '0;
    mem_wb       = '0;
    test_reset();
    test_reset_mid_dump();
    test_load();
    test_latch_dump();
    test_regs();
    test_step();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- On-chip end of the host debug protocol; the host PC drives it over UART.
- Sits between the uart_rx/uart_tx pair and the MIPS pipeline.
- Decodes host command bytes, loads programs into instruction memory, and controls run/step/stall.
- Serializes register-file and pipeline-latch snapshots back to the host, LSB byte first.

Parameters:
- SIZE, 32, data word width.
- NUM_REGISTERS, 32, register-file entries dumped by cmd 0x01.
- MAX_INSTRUCTION, 64, instruction-memory depth in words.
- IF_ID_SIZE, 32, IF/ID latch width in bits.
- ID_EX_SIZE, 129, ID/EX latch width in bits.
- EX_MEM_SIZE, 77, EX/MEM latch width in bits.
- MEM_WB_SIZE, 71, MEM/WB latch width in bits.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_rx_data  in  8  byte from uart_rx.
- i_rx_valid  in  1  one-cycle pulse: i_rx_data is valid.
- i_tx_done  in  1  one-cycle pulse: uart_tx finished the current byte.
- o_tx_data  out  8  byte to uart_tx.
- o_tx_start  out  1  one-cycle pulse to start transmitting o_tx_data.
- o_reg_addr  out  5  register-file read address; combinational read, data valid the same cycle.
- i_reg_data  in  SIZE  register-file read data.
- i_if_id, i_id_ex, i_ex_mem, i_mem_wb  in  the matching *_SIZE params  live pipeline latches.
- o_imem_we  out  1  instruction-memory write strobe.
- o_imem_addr  out  6  instruction word index.
- o_imem_data  out  SIZE  instruction word to write.
- o_stall  out  1  1 = pipeline frozen.
- o_pipe_rst  out  1  one-cycle pipeline/PC reset pulse.
- o_step_mode  out  1  1 = step-by-step mode.
- o_overrun  out  1  sticky flag: a command was dropped; cleared only by reset.

Behaviour:
- Reset values: all outputs 0 except o_stall=1; mode=continuous; FSM in IDLE; pending slot empty.
- Command codes:
  - 0x01 dump NUM_REGISTERS regs, 4 bytes each.
  - 0x02-0x05 dump IF/ID, ID/EX, EX/MEM, MEM/WB; ceil(W/8) bytes = 4/17/10/9, top byte zero-padded.
  - 0x07 load program.
  - 0x08 continuous mode; 0x09 step mode.
  - 0x0A step.
  - 0x0D start.
  - 0x11 pipeline reset.
  - Any other code is ignored, with no response.
- FSM states: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, SEND, SEND_WAIT.
- IDLE: a byte on i_rx_valid is decoded in the same cycle; mode/start/step/reset actions take effect on the next edge.
- 0x0D: o_stall<=0 in continuous mode. In step mode it is a no-op apart from arming 0x0A.
- 0x0A: honoured only in step mode after 0x0D; drives o_stall=0 for exactly one cycle. Otherwise ignored.
- 0x11: o_pipe_rst=1 for one cycle; o_stall<=1; start disarmed.
- 0x07 load, entry: o_stall<=1 and o_pipe_rst pulses; go to LOAD_CNT.
- LOAD_CNT: the next byte is N.
  - N=0 returns to IDLE.
  - Otherwise gather 4*N bytes, little-endian (first byte = bits 7:0).
- LOAD_WR: after each 4th byte, o_imem_we=1 for one cycle with o_imem_addr=k, k=0..N-1.
  - Words with k>=MAX_INSTRUCTION are consumed but not written.
- Dumps (0x01-0x05):
  - Latch inputs are snapshotted on the decode cycle.
  - Registers are read live, address 0..31, each word taken when its first byte is loaded.
  - SEND: o_tx_start pulses once; SEND_WAIT waits for i_tx_done, then the next byte.
  - Return to IDLE after the last i_tx_done.
- Dump latency: first o_tx_start occurs 2 cycles after i_rx_valid.
- Bytes arriving during SEND/SEND_WAIT: one pending slot holds a single command byte.
  - A second byte while the slot is full is dropped and sets o_overrun.
  - Pending commands execute in arrival order on return to IDLE.
- Bytes arriving during LOAD_* are data, never commands.
- i_rx_valid in the same cycle as i_tx_done: both are handled (the byte goes to the pending slot, the byte counter advances).
- Byte counters are 8-bit and never wrap within a command (max 128 bytes).
- Reset mid-operation: any transfer is aborted immediately, memory-write state is discarded, and the pending slot is cleared.

Decomposition:
- Package debug_pkg holds:
  - command code localparams (CMD_REGS=8'h01 … CMD_PRST=8'h11);
  - FSM state encoding;
  - the byte-count function ceil(W/8).
- Sub-module debug_tx_serializer, natural and self-contained:
  - loads a word of up to 136 bits plus a byte count;
  - runs the o_tx_start / i_tx_done handshake;
  - reports done.

Test Plan:
- Reset low mid-dump, then release -> o_tx_start stays 0; o_stall=1; next 0x02 yields a correct 4-byte reply.
- 0x07, 0x02, bytes 01 01 01 3C 03 00 03 3C -> o_imem_we at addr 0 with 32'h3C010101, then addr 1 with 32'h3C030003; o_stall=1; exactly one o_pipe_rst pulse.
- i_id_ex=129'h1_0000…00AB, send 0x03 -> 17 bytes AB,00,…,00,01; each o_tx_start only after the previous i_tx_done.
- Regs r[i]=i*16'h0101, send 0x01 -> 128 bytes; bytes 4..7 = 01,01,00,00.
- 0x09, 0x0D, 0x0A, 0x0A -> exactly two single-cycle o_stall=0 pulses; 0x0A before 0x0D -> none.
- During a 0x01 dump, send 0x02 then 0x03 -> the 0x02 reply follows the dump; 0x03 is dropped; o_overrun=1.
